// File: rtl/traffic_light_pkg.sv
// Shared types and helpers for the traffic-light lamp monitor.
// lamp_t deliberately reuses the controller's own colour encoding so that
// phase_id can be compared directly against controller state in a bench.
package traffic_light_pkg;

    // Monitor tracking state: idle, one of the three lit phases, or multi-lamp fault
    typedef enum logic [2:0] {
        S_OFF    = 3'd0,
        S_GREEN  = 3'd1,
        S_YELLOW = 3'd2,
        S_RED    = 3'd3,
        S_FAULT  = 3'd4
    } state_t;

    // Lamp colour, also used as the reported phase_id
    typedef enum logic [1:0] {
        LAMP_GREEN  = 2'd0,
        LAMP_YELLOW = 2'd1,
        LAMP_RED    = 2'd2,
        LAMP_OFF    = 2'd3
    } lamp_t;

    // Saturation ceiling of the 32-bit phase run counter
    localparam logic [31:0] RUN_MAX = 32'hFFFF_FFFF;

    // Colour currently being measured in a given tracking state
    function automatic lamp_t state_to_lamp(input state_t s);
        case (s)
            S_GREEN:  return LAMP_GREEN;
            S_YELLOW: return LAMP_YELLOW;
            S_RED:    return LAMP_RED;
            default:  return LAMP_OFF;
        endcase
    endfunction

    // Tracking state entered when a single lamp is seen
    function automatic state_t lamp_to_state(input lamp_t l);
        case (l)
            LAMP_GREEN:  return S_GREEN;
            LAMP_YELLOW: return S_YELLOW;
            LAMP_RED:    return S_RED;
            default:     return S_OFF;
        endcase
    endfunction

    // Only the forward rotation green -> yellow -> red -> green is legal
    function automatic logic is_legal_step(input lamp_t from, input lamp_t to);
        return ((from == LAMP_GREEN)  && (to == LAMP_YELLOW)) ||
               ((from == LAMP_YELLOW) && (to == LAMP_RED))    ||
               ((from == LAMP_RED)    && (to == LAMP_GREEN));
    endfunction

endpackage

// File: rtl/phase_len_counter.sv
// Saturating run-length counter for the lamp currently lit.
// Priority: zero over load-1 over increment. at_expected flags that the
// count already equals a nonzero expected length (zero means "no check").
module phase_len_counter
    import traffic_light_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_zero,
    input  logic        i_load1,
    input  logic        i_inc,
    input  logic [31:0] i_expected,
    output logic [31:0] o_run_len,
    output logic        o_at_expected
);

    logic [31:0] r_run_len;

    // Run counter: cleared on off/multi, restarted at 1 on a new lamp, else counts up and saturates
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_run_len <= 32'd0;
        end else if (i_zero) begin
            r_run_len <= 32'd0;
        end else if (i_load1) begin
            r_run_len <= 32'd1;
        end else if (i_inc && (r_run_len != RUN_MAX)) begin
            r_run_len <= r_run_len + 32'd1;
        end
    end

    assign o_run_len     = r_run_len;
    assign o_at_expected = (i_expected != 32'd0) && (r_run_len == i_expected);

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive checker on the traffic-light lamp outputs. Decodes the lit lamp,
// measures each phase, checks green->yellow->red order and phase lengths
// against the controller's ratio words, and reports sticky error flags.
module traffic_light_monitor
    import traffic_light_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             greenlt,
    input  logic             yellowlt,
    input  logic             redlt,
    input  logic [31:0]      ratioGreenLt,
    input  logic [31:0]      ratioYellowLt,
    input  logic [31:0]      ratioRedLt,
    output logic             phase_done,
    output logic [1:0]       phase_id,
    output logic [31:0]      phase_len,
    output logic [CNT_W-1:0] cycles_done,
    output logic             err_seq,
    output logic             err_len,
    output logic             err_multi
);

    // Decoded lamp inputs
    logic        w_off;
    logic        w_multi;
    logic        w_single;
    lamp_t       w_lamp;

    // Relationship between the sampled lamp and the phase being measured
    lamp_t       w_cur_lamp;
    logic        w_in_phase;
    logic        w_same;
    logic        w_change;
    logic        w_legal;
    logic [31:0] w_expected;

    // Run counter interface
    logic        w_cnt_zero;
    logic        w_cnt_load1;
    logic        w_cnt_inc;
    logic [31:0] w_run_len;
    logic        w_at_expected;
    logic        w_len_mismatch;

    // Event strobes for the sticky flags and cycle counter
    logic        w_set_seq;
    logic        w_set_len;
    logic        w_cycle_inc;

    // Registered state and outputs
    state_t           r_state;
    logic             r_phase_done;
    lamp_t            r_phase_id;
    logic [31:0]      r_phase_len;
    logic [CNT_W-1:0] r_cycles_done;
    logic             r_err_seq;
    logic             r_err_len;
    logic             r_err_multi;

    // Lamp decode: exactly one lamp lit is a colour, none is off, anything else is multi
    always_comb begin
        w_off   = 1'b0;
        w_multi = 1'b0;
        w_lamp  = LAMP_OFF;
        case ({greenlt, yellowlt, redlt})
            3'b000:  w_off   = 1'b1;
            3'b100:  w_lamp  = LAMP_GREEN;
            3'b010:  w_lamp  = LAMP_YELLOW;
            3'b001:  w_lamp  = LAMP_RED;
            default: w_multi = 1'b1;
        endcase
    end

    assign w_single   = !w_off && !w_multi;
    assign w_cur_lamp = state_to_lamp(r_state);
    assign w_in_phase = (w_cur_lamp != LAMP_OFF);
    assign w_same     = w_in_phase && w_single && (w_lamp == w_cur_lamp);
    assign w_change   = w_in_phase && w_single && (w_lamp != w_cur_lamp);
    assign w_legal    = is_legal_step(w_cur_lamp, w_lamp);

    // Expected length of the phase currently being measured (0 = unchecked)
    always_comb begin
        w_expected = 32'd0;
        case (w_cur_lamp)
            LAMP_GREEN:  w_expected = ratioGreenLt;
            LAMP_YELLOW: w_expected = ratioYellowLt;
            LAMP_RED:    w_expected = ratioRedLt;
            default:     w_expected = 32'd0;
        endcase
    end

    // Counter is idle at 0 while dark or faulted, and restarts at 1 on any
    // newly seen lamp so the first sample of a phase already counts as one cycle
    assign w_cnt_zero  = w_off || w_multi;
    assign w_cnt_load1 = w_single && !w_same;
    assign w_cnt_inc   = w_same;

    phase_len_counter u_phase_len_counter (
        .clk           (clk),
        .reset         (reset),
        .i_zero        (w_cnt_zero),
        .i_load1       (w_cnt_load1),
        .i_inc         (w_cnt_inc),
        .i_expected    (w_expected),
        .o_run_len     (w_run_len),
        .o_at_expected (w_at_expected)
    );

    assign w_len_mismatch = (w_expected != 32'd0) && (w_run_len != w_expected);

    // Length error: overrun while still lit, or wrong length when the phase ends
    assign w_set_len = (w_same && w_at_expected) || (w_change && w_len_mismatch);

    // Order error: illegal colour step, start from dark on anything but green,
    // or a lit phase going dark. Resync out of fault is deliberately exempt.
    assign w_set_seq = (w_change && !w_legal) ||
                       ((r_state == S_OFF) && w_single && (w_lamp != LAMP_GREEN)) ||
                       (w_in_phase && w_off);

    assign w_cycle_inc = w_change && w_legal && (w_cur_lamp == LAMP_RED);

    // Tracking FSM with registered phase report, sticky flags and cycle count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_OFF;
            r_phase_done  <= 1'b0;
            r_phase_id    <= LAMP_OFF;
            r_phase_len   <= 32'd0;
            r_cycles_done <= '0;
            r_err_seq     <= 1'b0;
            r_err_len     <= 1'b0;
            r_err_multi   <= 1'b0;
        end else begin
            // Every state follows the sampled lamp directly; the state only
            // remembers which rules apply to the next sample
            if (w_multi) begin
                r_state <= S_FAULT;
            end else if (w_off) begin
                r_state <= S_OFF;
            end else begin
                r_state <= lamp_to_state(w_lamp);
            end

            // Phase report only on lamp-to-lamp changes; id/len hold otherwise
            r_phase_done <= w_change;
            if (w_change) begin
                r_phase_id  <= w_cur_lamp;
                r_phase_len <= w_run_len;
            end

            // A new event in the same cycle as clear takes precedence
            if (w_set_seq) begin
                r_err_seq <= 1'b1;
            end else if (clear) begin
                r_err_seq <= 1'b0;
            end

            if (w_set_len) begin
                r_err_len <= 1'b1;
            end else if (clear) begin
                r_err_len <= 1'b0;
            end

            if (w_multi) begin
                r_err_multi <= 1'b1;
            end else if (clear) begin
                r_err_multi <= 1'b0;
            end

            if (w_cycle_inc) begin
                if (r_cycles_done != '1) begin
                    r_cycles_done <= r_cycles_done + CNT_W'(1);
                end
            end else if (clear) begin
                r_cycles_done <= '0;
            end
        end
    end

    assign phase_done  = r_phase_done;
    assign phase_id    = r_phase_id;
    assign phase_len   = r_phase_len;
    assign cycles_done = r_cycles_done;
    assign err_seq     = r_err_seq;
    assign err_len     = r_err_len;
    assign err_multi   = r_err_multi;

endmodule
